// File: rtl/axi_full_s_ram_if.sv
// AXI4 full slave-side bus bundle (no ID/SIZE/BURST/USER signals; INCR, full-width only).
interface axi_full_s_ram_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [7:0]                      S_AXI_AWLEN;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WLAST;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [7:0]                      S_AXI_ARLEN;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RLAST;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
    );
endinterface

// File: rtl/axi_full_s_ram.sv
// AXI4 full slave backed by a word-addressed RAM; one outstanding write and one
// outstanding read, with independent write and read FSMs.
module axi_full_s_ram #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_MEM_ADDR_BITS  = 10
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESETN,
    axi_full_s_ram_if.slave    s_axi
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int NB    = DW / 8;
    localparam int LSB   = $clog2(NB);
    localparam int MB    = C_S_MEM_ADDR_BITS;
    localparam int DEPTH = 1 << MB;
    localparam logic [MB-1:0] IDX_ONE = MB'(1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    logic [DW-1:0] mem [DEPTH];

    // Holds both ready outputs low until the first edge after reset release.
    logic rst_done_q;

    w_state_e      w_state_q, w_state_d;
    logic [MB-1:0] w_idx_q, w_idx_d;
    logic [7:0]    w_len_q, w_len_d;
    logic [8:0]    w_cnt_q, w_cnt_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          mem_we;
    logic          awready, wready, bvalid;

    r_state_e      r_state_q, r_state_d;
    logic [MB-1:0] r_idx_q, r_idx_d;
    logic [7:0]    r_len_q, r_len_d;
    logic [7:0]    r_cnt_q, r_cnt_d;
    logic [DW-1:0] rdata_q;
    logic          rdata_ld;
    logic [MB-1:0] rd_idx;
    logic          arready, rvalid, rlast;

    wire [C_S_AXI_ADDR_WIDTH-1:0] unused_awaddr = s_axi.S_AXI_AWADDR;
    wire [C_S_AXI_ADDR_WIDTH-1:0] unused_araddr = s_axi.S_AXI_ARADDR;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rst_done_q <= 1'b0;
            w_state_q  <= W_IDLE;
            w_idx_q    <= '0;
            w_len_q    <= '0;
            w_cnt_q    <= '0;
            bresp_q    <= 2'b00;
            r_state_q  <= R_IDLE;
            r_idx_q    <= '0;
            r_len_q    <= '0;
            r_cnt_q    <= '0;
            rdata_q    <= '0;
        end else begin
            rst_done_q <= 1'b1;
            w_state_q  <= w_state_d;
            w_idx_q    <= w_idx_d;
            w_len_q    <= w_len_d;
            w_cnt_q    <= w_cnt_d;
            bresp_q    <= bresp_d;
            r_state_q  <= r_state_d;
            r_idx_q    <= r_idx_d;
            r_len_q    <= r_len_d;
            r_cnt_q    <= r_cnt_d;
            // Non-blocking read gives pre-write data on a same-cycle collision.
            if (rdata_ld) rdata_q <= mem[rd_idx];
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi.S_AXI_WSTRB[b]) mem[w_idx_q][b*8 +: 8] <= s_axi.S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready = rst_done_q;
                if (awready && s_axi.S_AXI_AWVALID) begin
                    w_idx_d   = s_axi.S_AXI_AWADDR[LSB +: MB];
                    w_len_d   = s_axi.S_AXI_AWLEN;
                    w_cnt_d   = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (s_axi.S_AXI_WVALID) begin
                    // Beats past AWLEN are accepted but dropped; the count
                    // saturates so a runaway burst still reports SLVERR.
                    mem_we = (w_cnt_q <= {1'b0, w_len_q});
                    if (mem_we) w_idx_d = w_idx_q + IDX_ONE;
                    if (w_cnt_q != '1) w_cnt_d = w_cnt_q + 9'd1;
                    if (s_axi.S_AXI_WLAST) begin
                        bresp_d   = (w_cnt_q == {1'b0, w_len_q}) ? 2'b00 : 2'b10;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (s_axi.S_AXI_BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        rdata_ld  = 1'b0;
        rd_idx    = r_idx_q;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                arready = rst_done_q;
                if (arready && s_axi.S_AXI_ARVALID) begin
                    r_len_d   = s_axi.S_AXI_ARLEN;
                    r_cnt_d   = '0;
                    rdata_ld  = 1'b1;
                    rd_idx    = s_axi.S_AXI_ARADDR[LSB +: MB];
                    r_idx_d   = rd_idx + IDX_ONE;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = (r_cnt_q == r_len_q);
                if (s_axi.S_AXI_RREADY) begin
                    if (rlast) begin
                        r_state_d = R_IDLE;
                    end else begin
                        rdata_ld = 1'b1;
                        r_idx_d  = r_idx_q + IDX_ONE;
                        r_cnt_d  = r_cnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RVALID  = rvalid;
    assign s_axi.S_AXI_RLAST   = rlast;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = 2'b00;
endmodule
